demux2_reg: RTL and testbench

Registered 1-to-2 stream demultiplexer with valid/ready handshakes. It routes each input word to one of two consumers, selected by `s`, through one holding register per output. It is the inverse of the 2:1 datapath mux: one producer fans out to two consumers, for example a result bus split between a writeback path and a store path. Each output drains independently, so back-pressure on one output does not block traffic to the other.

---
 rtl/demux2_reg.sv | 82 ++++++++
 tb/tb_demux2_reg.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/demux2_reg.sv
// rtl/demux2_reg.sv - registered 1-to-2 valid/ready stream demux, one holding slot per output
// Optional transfer counters on cnt0/cnt1 are built only when DEMUX2_STATS_EN is defined.
module demux2_reg #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  input  logic             s,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y0,
  output logic             y0_valid,
  input  logic             y0_ready,
  output logic [WIDTH-1:0] y1,
  output logic             y1_valid,
  input  logic             y1_ready,
  output logic [15:0]      cnt0,
  output logic [15:0]      cnt1
);

  logic             r_full0;
  logic             r_full1;
  logic [WIDTH-1:0] r_y0;
  logic [WIDTH-1:0] r_y1;

  logic w_accept;
  logic w_accept0;
  logic w_accept1;
  logic w_drain0;
  logic w_drain1;

  // A full slot that is draining this cycle can take the next word (pass-through refill).
  assign in_ready  = s ? (!r_full1 || y1_ready) : (!r_full0 || y0_ready);
  assign w_accept  = in_valid && in_ready;
  assign w_accept0 = w_accept && !s;
  assign w_accept1 = w_accept && s;
  assign w_drain0  = r_full0 && y0_ready;
  assign w_drain1  = r_full1 && y1_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_full0 <= 1'b0;
      r_full1 <= 1'b0;
      r_y0    <= '0;
      r_y1    <= '0;
    end else begin
      r_full0 <= w_accept0 || (r_full0 && !w_drain0);
      r_full1 <= w_accept1 || (r_full1 && !w_drain1);
      if (w_accept0) r_y0 <= d;
      if (w_accept1) r_y1 <= d;
    end
  end

  assign y0       = r_y0;
  assign y1       = r_y1;
  assign y0_valid = r_full0;
  assign y1_valid = r_full1;

`ifdef DEMUX2_STATS_EN
  logic [15:0] r_cnt0;
  logic [15:0] r_cnt1;

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_drain0 && (r_cnt0 != 16'hFFFF)) r_cnt0 <= r_cnt0 + 16'd1;
      if (w_drain1 && (r_cnt1 != 16'hFFFF)) r_cnt1 <= r_cnt1 + 16'd1;
    end
  end

  assign cnt0 = r_cnt0;
  assign cnt1 = r_cnt1;
`else
  assign cnt0 = 16'd0;
  assign cnt1 = 16'd0;
`endif

endmodule

// File: tb/tb_demux2_reg.sv
// tb/tb_demux2_reg.sv - self-checking bench for demux2_reg: queue model plus directed and random stimulus
module tb_demux2_reg;
  localparam int WIDTH = 9;

  logic             clk;
  logic             reset_n;
  logic [WIDTH-1:0] d;
  logic             s;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] y0;
  logic             y0_valid;
  logic             y0_ready;
  logic [WIDTH-1:0] y1;
  logic             y1_valid;
  logic             y1_ready;
  logic [15:0]      cnt0;
  logic [15:0]      cnt1;

  int n_tests = 0;
  int n_fail  = 0;

  demux2_reg #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset_n(reset_n), .d(d), .s(s), .in_valid(in_valid), .in_ready(in_ready),
    .y0(y0), .y0_valid(y0_valid), .y0_ready(y0_ready),
    .y1(y1), .y1_valid(y1_valid), .y1_ready(y1_ready),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: each output is a queue holding at most one undelivered word.
  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];
  longint           drains0, drains1;
  bit               m_init = 0;
  bit               m_acc;

  function automatic bit model_ready();
    if (s) return (q1.size() == 0) || y1_ready;
    else   return (q0.size() == 0) || y0_ready;
  endfunction

  function automatic logic [15:0] model_cnt(input longint n);
`ifdef DEMUX2_STATS_EN
    return (n > 65535) ? 16'hFFFF : n[15:0];
`else
    return (n >= 0) ? 16'd0 : 16'd0;
`endif
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      q0.delete();
      q1.delete();
      drains0 = 0;
      drains1 = 0;
      m_init  = 1;
    end else if (m_init) begin
      m_acc = in_valid && model_ready();
      if (q0.size() != 0 && y0_ready) begin void'(q0.pop_front()); drains0++; end
      if (q1.size() != 0 && y1_ready) begin void'(q1.pop_front()); drains1++; end
      if (m_acc) begin
        if (s) q1.push_back(d);
        else   q0.push_back(d);
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      check("in_ready",  {31'd0, in_ready}, {31'd0, model_ready()});
      check("y0_valid",  {31'd0, y0_valid}, {31'd0, q0.size() != 0});
      check("y1_valid",  {31'd0, y1_valid}, {31'd0, q1.size() != 0});
      if (q0.size() != 0) check("y0_data", {23'd0, y0}, {23'd0, q0[0]});
      if (q1.size() != 0) check("y1_data", {23'd0, y1}, {23'd0, q1[0]});
      check("cnt0", {16'd0, cnt0}, {16'd0, model_cnt(drains0)});
      check("cnt1", {16'd0, cnt1}, {16'd0, model_cnt(drains1)});
    end
  end

  // Inputs change 1 time unit after the rising edge; returns at the following falling edge.
  task automatic cyc(input logic rn, input logic iv, input logic ss, input logic [WIDTH-1:0] dd,
                     input logic r0, input logic r1);
    @(posedge clk);
    #1;
    reset_n = rn; in_valid = iv; s = ss; d = dd; y0_ready = r0; y1_ready = r1;
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; s = 1'b0; d = '0; y0_ready = 1'b0; y1_ready = 1'b0;

    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_y0_valid", {31'd0, y0_valid}, 32'd0);
    check("rst_y1_valid", {31'd0, y1_valid}, 32'd0);
    check("rst_y0", {23'd0, y0}, 32'd0);
    check("rst_y1", {23'd0, y1}, 32'd0);
    check("rst_cnt0", {16'd0, cnt0}, 32'd0);
    check("rst_cnt1", {16'd0, cnt1}, 32'd0);

    // basic route
    cyc(1, 1, 0, 9'h155, 1, 0);
    check("route_ready", {31'd0, in_ready}, 32'd1);
    cyc(1, 1, 1, 9'h199, 1, 0);
    check("route_y0_valid", {31'd0, y0_valid}, 32'd1);
    check("route_y0", {23'd0, y0}, 32'h155);
    cyc(1, 0, 0, 0, 1, 1);
    check("route_y0_once", {31'd0, y0_valid}, 32'd0);
    check("route_y1_valid", {31'd0, y1_valid}, 32'd1);
    check("route_y1", {23'd0, y1}, 32'h199);

    // back-pressure on output 0 does not block output 1
    cyc(1, 1, 0, 9'h155, 0, 0);
    cyc(1, 1, 0, 9'h0AA, 0, 0);
    check("bp_y0", {23'd0, y0}, 32'h155);
    check("bp_blocked", {31'd0, in_ready}, 32'd0);
    cyc(1, 1, 1, 9'h199, 0, 0);
    check("bp_other_ready", {31'd0, in_ready}, 32'd1);
    cyc(1, 0, 0, 0, 0, 0);
    check("bp_y1", {23'd0, y1}, 32'h199);
    check("bp_y0_hold", {23'd0, y0}, 32'h155);
    cyc(1, 0, 0, 0, 1, 1);
    cyc(1, 0, 0, 0, 0, 0);
    check("bp_drained0", {31'd0, y0_valid}, 32'd0);
    check("bp_drained1", {31'd0, y1_valid}, 32'd0);

    // streaming 0..7 to output 0 after a fresh reset
    cyc(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(1, 1, 0, WIDTH'(i), 1, 0);
      check("stream_ready", {31'd0, in_ready}, 32'd1);
      if (i > 0) check("stream_y0", {23'd0, y0}, i - 1);
    end
    cyc(1, 0, 0, 0, 1, 0);
    check("stream_last", {23'd0, y0}, 32'd7);
    cyc(1, 0, 0, 0, 1, 0);
    check("stream_empty", {31'd0, y0_valid}, 32'd0);
`ifdef DEMUX2_STATS_EN
    check("stream_cnt0", {16'd0, cnt0}, 32'd8);
`else
    check("stream_cnt0", {16'd0, cnt0}, 32'd0);
`endif

    // reset with both slots full discards them
    cyc(1, 1, 0, 9'h155, 0, 0);
    cyc(1, 1, 1, 9'h199, 0, 0);
    cyc(0, 0, 0, 0, 1, 1);
    check("mid_full0", {31'd0, y0_valid}, 32'd1);
    check("mid_full1", {31'd0, y1_valid}, 32'd1);
    cyc(1, 0, 0, 0, 1, 1);
    check("mid_gone0", {31'd0, y0_valid}, 32'd0);
    check("mid_gone1", {31'd0, y1_valid}, 32'd0);

    // random traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      cyc(logic'($urandom_range(0, 63) != 0), logic'($urandom_range(0, 3) != 0),
          logic'($urandom_range(0, 1)), WIDTH'($urandom),
          logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 3) != 0));
    end

`ifdef DEMUX2_STATS_EN
    cyc(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 65537; i++) cyc(1, 1, 1, WIDTH'($urandom), 0, 1);
    cyc(1, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 1);
    check("sat_cnt1", {16'd0, cnt1}, 32'hFFFF);
    check("sat_cnt0", {16'd0, cnt0}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
